// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl
// Purpose  : Sequencer for an N x N output-stationary systolic multiply array.
//            Buffers operand matrices A and B, clears the array accumulators,
//            drives the skewed west (A) and north (B) operand wavefront,
//            waits out the drain period, then captures the accumulators and
//            presents them on a valid/ready result port.
// Options  : SYSTOLIC_CTRL_PERF_EN adds the perf_jobs / perf_busy counters.
// Revision : 1.0  initial release
// ============================================================================
module systolic_ctrl #(
    parameter int N         = 4,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 16,
    parameter int DRAIN_CYC = 2 * N
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [$clog2(N)-1:0]   wr_row,
    input  logic [N*DATA_W-1:0]    wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   arr_clr,
    output logic [N*DATA_W-1:0]    arr_a_in,
    output logic [N*DATA_W-1:0]    arr_b_in,
    input  logic [N*N*ACC_W-1:0]   arr_c,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [N*N*ACC_W-1:0]   res_data
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [15:0]            perf_jobs,
    output logic [31:0]            perf_busy
`endif
);

    // Counter is shared by FEED (0..3N-3) and DRAIN (0..DRAIN_CYC-1).
    localparam int c_cnt_w      = $clog2(3 * N + DRAIN_CYC);
    localparam int c_feed_last  = 3 * N - 3;
    localparam int c_drain_last = DRAIN_CYC - 1;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_clear   = 3'd1;
    localparam logic [2:0] c_st_feed    = 3'd2;
    localparam logic [2:0] c_st_drain   = 3'd3;
    localparam logic [2:0] c_st_capture = 3'd4;
    localparam logic [2:0] c_st_done    = 3'd5;

    logic [2:0]               r_state;
    logic [c_cnt_w-1:0]       r_cnt;
    logic                     r_busy;
    logic                     r_clr;
    logic                     r_valid;
    logic [N*DATA_W-1:0]      r_a_edge;
    logic [N*DATA_W-1:0]      r_b_edge;
    logic [N*N*ACC_W-1:0]     r_res;
    logic [N*DATA_W-1:0]      r_a_buf [N];
    logic [N*DATA_W-1:0]      r_b_buf [N];

    logic                     w_load_feed;
    logic [c_cnt_w-1:0]       w_t_next;
    logic [N*DATA_W-1:0]      w_a_edge;
    logic [N*DATA_W-1:0]      w_b_edge;

    // Wavefront index of the FEED cycle that begins at the coming edge.
    always_comb begin
        w_load_feed = 1'b0;
        w_t_next    = '0;
        if (r_state == c_st_clear) begin
            w_load_feed = 1'b1;
        end else if (r_state == c_st_feed && r_cnt != c_cnt_w'(c_feed_last)) begin
            w_load_feed = 1'b1;
            w_t_next    = r_cnt + c_cnt_w'(1);
        end
    end

    // Skewed edge values: lane i carries element k when t == i + k.
    always_comb begin
        w_a_edge = '0;
        w_b_edge = '0;
        if (w_load_feed) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (w_t_next == c_cnt_w'(i + k)) begin
                        w_a_edge[i*DATA_W +: DATA_W] = r_a_buf[i][k*DATA_W +: DATA_W];
                        w_b_edge[i*DATA_W +: DATA_W] = r_b_buf[k][i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Operand row buffers; written only while idle, kept across jobs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_a_buf[i] <= '0;
                r_b_buf[i] <= '0;
            end
        end else if (r_state == c_st_idle && wr_en && (int'(wr_row) < N)) begin
            if (wr_sel) begin
                r_b_buf[wr_row] <= wr_data;
            end else begin
                r_a_buf[wr_row] <= wr_data;
            end
        end
    end

    // Job sequencer with registered edge, clear and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_clr    <= 1'b1;
            r_valid  <= 1'b0;
            r_a_edge <= '0;
            r_b_edge <= '0;
            r_res    <= '0;
        end else begin
            r_clr    <= 1'b0;
            r_a_edge <= w_a_edge;
            r_b_edge <= w_b_edge;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_clear;
                        r_busy  <= 1'b1;
                        r_clr   <= 1'b1;
                    end
                end
                c_st_clear: begin
                    r_state <= c_st_feed;
                    r_cnt   <= '0;
                end
                c_st_feed: begin
                    if (r_cnt == c_cnt_w'(c_feed_last)) begin
                        r_state <= c_st_drain;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_drain: begin
                    if (r_cnt == c_cnt_w'(c_drain_last)) begin
                        r_state <= c_st_capture;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_capture: begin
                    r_res   <= arr_c;
                    r_valid <= 1'b1;
                    r_state <= c_st_done;
                end
                c_st_done: begin
                    // res_valid is always high here, so ready alone completes it.
                    if (res_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign arr_clr   = r_clr;
    assign arr_a_in  = r_a_edge;
    assign arr_b_in  = r_b_edge;
    assign res_valid = r_valid;
    assign res_data  = r_res;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0] r_perf_jobs;
    logic [31:0] r_perf_busy;

    // Completed-job count (wrapping) and busy-cycle count (saturating).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_jobs <= '0;
            r_perf_busy <= '0;
        end else begin
            if (r_state == c_st_done && res_ready) begin
                r_perf_jobs <= r_perf_jobs + 16'd1;
            end
            if (r_busy && r_perf_busy != 32'hFFFF_FFFF) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
        end
    end

    assign perf_jobs = r_perf_jobs;
    assign perf_busy = r_perf_busy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_ctrl
// Purpose  : Self-checking bench for systolic_ctrl. A cycle model of the
//            output-stationary array closes the loop on arr_c; expected
//            results come from a plain matrix product of the bench's own
//            copies of A and B, expected edges from the skew formula.
// Options  : SYSTOLIC_CTRL_PERF_EN enables the perf counter checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_systolic_ctrl;

    localparam int N         = 4;
    localparam int DATA_W    = 8;
    localparam int ACC_W     = 16;
    localparam int DRAIN_CYC = 2 * N;
    localparam int RW        = $clog2(N);
    localparam int CW        = N * N * ACC_W;
    localparam int LAT       = 1 + (3 * N - 2) + DRAIN_CYC + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n = 1'b0;
    logic                 wr_en = 1'b0;
    logic                 wr_sel = 1'b0;
    logic [RW-1:0]        wr_row = '0;
    logic [N*DATA_W-1:0]  wr_data = '0;
    logic                 start = 1'b0;
    logic                 res_ready = 1'b0;
    logic                 busy, arr_clr, res_valid;
    logic [N*DATA_W-1:0]  arr_a_in, arr_b_in;
    logic [CW-1:0]        arr_c, res_data;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0]          perf_jobs;
    logic [31:0]          perf_busy;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int mA [N][N];
    int mB [N][N];

    systolic_ctrl #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .DRAIN_CYC(DRAIN_CYC)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .arr_clr   (arr_clr),
        .arr_a_in  (arr_a_in),
        .arr_b_in  (arr_b_in),
        .arr_c     (arr_c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_jobs (perf_jobs),
        .perf_busy (perf_busy)
`endif
    );

    // ---------------- array model (the DUT's neighbour) ----------------
    logic [DATA_W-1:0] pa   [N][N];
    logic [DATA_W-1:0] pb   [N][N];
    logic [ACC_W-1:0]  acc  [N][N];
    logic [DATA_W-1:0] ain  [N][N];
    logic [DATA_W-1:0] bin  [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ain[i][0] = arr_a_in[i*DATA_W +: DATA_W];
            bin[0][i] = arr_b_in[i*DATA_W +: DATA_W];
            for (int j = 1; j < N; j++) begin
                ain[i][j] = pa[i][j-1];
                bin[j][i] = pb[j-1][i];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (arr_clr) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end else begin
                    pa[i][j]  <= ain[i][j];
                    pb[i][j]  <= bin[i][j];
                    acc[i][j] <= acc[i][j] + ACC_W'(ain[i][j] * bin[i][j]);
                end
            end
        end
    end

    always_comb begin
        arr_c = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                arr_c[(i*N+j)*ACC_W +: ACC_W] = acc[i][j];
    end

    // ---------------- reference model ----------------
    function automatic logic [N*DATA_W-1:0] exp_west(input int t);
        logic [N*DATA_W-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*DATA_W +: DATA_W] = DATA_W'(mA[i][t-i]);
        return v;
    endfunction

    function automatic logic [N*DATA_W-1:0] exp_north(input int t);
        logic [N*DATA_W-1:0] v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*DATA_W +: DATA_W] = DATA_W'(mB[t-j][j]);
        return v;
    endfunction

    function automatic logic [CW-1:0] exp_c();
        logic [CW-1:0] v = '0;
        longint s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += longint'(mA[i][k]) * longint'(mB[k][j]);
                v[(i*N+j)*ACC_W +: ACC_W] = ACC_W'(s % (longint'(1) << ACC_W));
            end
        return v;
    endfunction

    function automatic logic [N*DATA_W-1:0] row_of(input bit sel, input int r);
        logic [N*DATA_W-1:0] v = '0;
        for (int k = 0; k < N; k++)
            v[k*DATA_W +: DATA_W] = sel ? DATA_W'(mB[r][k]) : DATA_W'(mA[r][k]);
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic write_row(input bit sel, input int r);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = RW'(r);
        wr_data = row_of(sel, r);
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic load_all();
        for (int r = 0; r < N; r++) begin
            write_row(1'b0, r);
            write_row(1'b1, r);
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mA[i][j] = 0;
                mB[i][j] = 0;
            end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_busy", CW'(busy), CW'(0));
        check_eq("rst_valid", CW'(res_valid), CW'(0));
        check_eq("rst_edges", CW'({arr_a_in, arr_b_in}), CW'(0));
        check_eq("rst_res", res_data, '0);
        check_eq("rst_clr", CW'(arr_clr), CW'(1));
        repeat (cycles - 1) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_clr_release", CW'(arr_clr), CW'(0));
        zero_model();
    endtask

    // One job; ov writes row N-1 of B in the start cycle, hold = cycles of backpressure.
    task automatic run_job(input bit ov, input int hold);
        int c;
        logic [CW-1:0] ref_c;
        res_ready = (hold == 0);
        if (ov) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b1;
            wr_row  = RW'(N - 1);
            wr_data = row_of(1'b1, N - 1);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        check_eq("busy_rise", CW'(busy), CW'(1));
        check_eq("clear_pulse", CW'(arr_clr), CW'(1));
        ref_c = exp_c();
        c = 0;
        while (c < LAT + 20) begin
            @(posedge clk); #1;
            c++;
            if (c <= 3 * N - 2) begin
                check_eq($sformatf("west_t%0d", c - 1), CW'(arr_a_in), CW'(exp_west(c - 1)));
                check_eq($sformatf("north_t%0d", c - 1), CW'(arr_b_in), CW'(exp_north(c - 1)));
            end else if (!res_valid) begin
                check_eq("drain_edges", CW'({arr_a_in, arr_b_in}), CW'(0));
            end
            if (res_valid) break;
        end
        check_eq("latency", CW'(c), CW'(LAT));
        check_eq("result", res_data, ref_c);
        if (hold == 0) begin
            start = 1'b1;  // must be ignored in the handshake cycle
        end
        for (int h = 0; h < hold; h++) begin
            wr_en   = 1'b1;
            wr_sel  = 1'($urandom_range(0, 1));
            wr_row  = RW'($urandom_range(0, N - 1));
            wr_data = N*DATA_W'($urandom);
            start   = 1'b1;
            @(posedge clk); #1;
            check_eq("bp_data", res_data, ref_c);
            check_eq("bp_busy_valid", CW'({busy, res_valid}), CW'(2'b11));
        end
        wr_en = 1'b0;
        if (hold != 0) begin
            start = 1'b0;
            res_ready = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("handshake", CW'({busy, res_valid}), CW'(2'b00));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        zero_model();
        repeat (2) @(posedge clk);
        #1;
        do_reset(2);

        // Reset in the middle of FEED, then a job on the zeroed buffers.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mA[i][j] = 1 + $urandom_range(0, 254);
                mB[i][j] = 1 + $urandom_range(0, 254);
            end
        load_all();
        start = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        do_reset(2);
        run_job(1'b0, 0);

        // Functional vector.
        mA = '{'{1,0,0,4}, '{0,2,0,8}, '{0,0,5,0}, '{0,0,3,4}};
        mB = '{'{0,7,6,0}, '{8,0,0,0}, '{0,0,6,0}, '{0,9,4,0}};
        load_all();
        run_job(1'b0, 0);

        // Skew: A all ones, B identity.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mA[i][j] = 1;
                mB[i][j] = (i == j) ? 1 : 0;
            end
        load_all();
        run_job(1'b0, 0);

        // Backpressure with ignored writes/start, then the same job again.
        run_job(1'b0, 10);
        run_job(1'b0, 0);

        // Accumulator wrap.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mA[i][j] = 255;
                mB[i][j] = 255;
            end
        load_all();
        run_job(1'b0, 0);

        // Random jobs, including a row write in the start cycle.
        for (int n = 0; n < 4; n++) begin
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(0, 1) == 1) begin
                    for (int k = 0; k < N; k++) mA[r][k] = $urandom_range(0, 255);
                    write_row(1'b0, r);
                end
                if ($urandom_range(0, 1) == 1) begin
                    for (int k = 0; k < N; k++) mB[r][k] = $urandom_range(0, 255);
                    write_row(1'b1, r);
                end
            end
            for (int k = 0; k < N; k++) mB[N-1][k] = $urandom_range(0, 255);
            run_job(1'b1, $urandom_range(0, 3));
        end

        // Two back-to-back jobs from reset.
        do_reset(2);
        run_job(1'b0, 0);
        run_job(1'b0, 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check_eq("perf_jobs", CW'(perf_jobs), CW'(2));
        check_eq("perf_busy", CW'(perf_busy), CW'(2 * (LAT + 1)));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
